bcd_conv_sched: RTL and testbench

Time-shares one start/done binary-to-BCD converter between N_CH requesters: fare, mileage and wait-time counters on the taxi meter. Arbitration is round-robin. The block captures the granted value, saturates it to the 6-digit display range, and sequences the converter. It then publishes the 6-digit BCD result, tagged with the channel, to the display register file. A watchdog recovers from a converter that never answers.

---
 rtl/bcd_sched_pkg.sv | 18 +
 rtl/rr_arbiter_n.sv | 29 ++
 rtl/bcd_conv_sched.sv | 141 ++++++++++++++
 tb/tb_bcd_conv_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// bcd_conv_sched shared definitions:
// FSM state encoding, display limit and taxi-meter channel indices.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  localparam logic [19:0] MAX_VAL_6DIG = 20'd999999;

  localparam int CH_FARE = 0;
  localparam int CH_MILE = 1;
  localparam int CH_WAIT = 2;

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotate-priority arbiter: first set request at or above ptr, wrapping.
// Ports: req (requests), ptr (start index), gnt (one-hot), idx, any.
module rr_arbiter_n #(
  parameter int N_CH = 3
) (
  input  logic [N_CH-1:0] req,
  input  logic [1:0]      ptr,
  output logic [N_CH-1:0] gnt,
  output logic [1:0]      idx,
  output logic            any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      j = (int'(ptr) + k) % N_CH;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one start/done binary-to-BCD converter.
// Ports: sys_clk/sys_rst; req_valid/req_data/req_ready (requesters);
//   conv_start/conv_data/conv_done/conv_bcd (converter);
//   res_valid/res_ch/res_bcd/res_ovf (display file); busy, timeout_err.
module bcd_conv_sched
  import bcd_sched_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DW      = 20,
  parameter int BCD_W   = 24,
  parameter int MAX_VAL = 999999,
  parameter int TIMEOUT = 63
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH*DW-1:0] req_data,
  output logic [N_CH-1:0]   req_ready,
  output logic              conv_start,
  output logic [DW-1:0]     conv_data,
  input  logic              conv_done,
  input  logic [BCD_W-1:0]  conv_bcd,
  output logic              res_valid,
  output logic [1:0]        res_ch,
  output logic [BCD_W-1:0]  res_bcd,
  output logic              res_ovf,
  output logic              busy,
  output logic              timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [DW-1:0] LIMIT = DW'(MAX_VAL);

  state_t state;
  state_t nxt;

  logic [1:0]      rr_ptr;
  logic [WDW-1:0]  wd;
  logic [1:0]      ch_r;
  logic            ovf_r;

  logic [N_CH-1:0] gnt;
  logic [1:0]      g_idx;
  logic            g_any;
  logic [DW-1:0]   g_data;
  logic            g_sat;

  rr_arbiter_n #(
    .N_CH (N_CH)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (g_idx),
    .any (g_any)
  );

  assign g_data = req_data[g_idx*DW +: DW];
  assign g_sat  = g_data > LIMIT;
  assign busy   = state != ST_IDLE;

  always_comb begin
    nxt         = state;
    req_ready   = '0;
    conv_start  = 1'b0;
    res_valid   = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // no accept while reset is held
        if (g_any && !sys_rst) begin
          req_ready = gnt;
          nxt       = ST_START;
        end
      end
      ST_START: begin
        conv_start = 1'b1;
        nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over expiry
        if (conv_done) begin
          nxt = ST_PUBLISH;
        end else if (wd == WD_MAX) begin
          timeout_err = 1'b1;
          nxt         = ST_IDLE;
        end
      end
      ST_PUBLISH: begin
        res_valid = 1'b1;
        nxt       = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      wd        <= '0;
      ch_r      <= '0;
      ovf_r     <= 1'b0;
      conv_data <= '0;
      res_ch    <= '0;
      res_bcd   <= '0;
      res_ovf   <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        ST_IDLE: begin
          if (g_any) begin
            conv_data <= g_sat ? LIMIT : g_data;
            ovf_r     <= g_sat;
            ch_r      <= g_idx;
            if (g_idx == 2'(N_CH - 1)) begin
              rr_ptr <= '0;
            end else begin
              rr_ptr <= g_idx + 2'd1;
            end
          end
        end
        ST_START: begin
          wd <= '0;
        end
        ST_WAIT: begin
          if (conv_done) begin
            res_bcd <= conv_bcd;
            res_ch  <= ch_r;
            res_ovf <= ovf_r;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_PUBLISH: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched with a behavioural converter model.
// Expected results come from a round-robin/saturation model of the rules.
module tb_bcd_conv_sched;

  localparam int N_CH    = 3;
  localparam int DW      = 20;
  localparam int BCD_W   = 24;
  localparam int TIMEOUT = 63;
  localparam int MAXV    = 999999;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic [N_CH-1:0]   req_valid = '0;
  logic [N_CH*DW-1:0] req_data = '0;
  logic [N_CH-1:0]   req_ready;
  logic              conv_start;
  logic [DW-1:0]     conv_data;
  logic              conv_done = 1'b0;
  logic [BCD_W-1:0]  conv_bcd = '0;
  logic              res_valid;
  logic [1:0]        res_ch;
  logic [BCD_W-1:0]  res_bcd;
  logic              res_ovf;
  logic              busy;
  logic              timeout_err;

  bcd_conv_sched #(
    .N_CH (N_CH), .DW (DW), .BCD_W (BCD_W),
    .MAX_VAL (MAXV), .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .req_valid (req_valid), .req_data (req_data),
    .req_ready (req_ready),
    .conv_start (conv_start), .conv_data (conv_data),
    .conv_done (conv_done), .conv_bcd (conv_bcd),
    .res_valid (res_valid), .res_ch (res_ch),
    .res_bcd (res_bcd), .res_ovf (res_ovf),
    .busy (busy), .timeout_err (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          ch;
    logic [23:0] bcd;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int   gorder[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_cnt[N_CH] = '{default: 0};
  int   taken[N_CH] = '{default: 0};
  int   res_cnt = 0;
  int   tmo_cnt = 0;
  int   conv_mode = 0;
  int   conv_delay = 3;
  int   stray_cnt = 0;
  int   stray_done = 0;
  bit   keep = 0;
  bit   rnd_mode = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r = '0;
    int p = 1;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return DW'(MAXV);
      2: return DW'(MAXV + 1);
      3: return '1;
      default: return DW'($urandom_range(0, 20'hFFFFF));
    endcase
  endfunction

  // grant model: rotate priority from exp_ptr, saturate, predict result
  int          exp_ptr = 0;
  bit          exp_start = 0;
  logic [DW-1:0] exp_cd;
  int          g;
  int          gv;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      exp_ptr   = 0;
      exp_start = 0;
    end else begin
      if (exp_start) begin
        check("conv_start", 32'(conv_start), 1);
        check("conv_data", 32'(conv_data), 32'(exp_cd));
        exp_start = 0;
      end else if (conv_start) begin
        check("stray_conv_start", 32'(conv_start), 0);
      end
      if (req_ready != 0) begin
        g = -1;
        for (int k = 0; k < N_CH; k++) begin
          if (g < 0 && req_valid[(exp_ptr + k) % N_CH])
            g = (exp_ptr + k) % N_CH;
        end
        check("req_ready", 32'(req_ready),
              g < 0 ? 32'd0 : 32'd1 << g);
        if (g >= 0) begin
          gv = int'(req_data[g*DW +: DW]);
          exp_cd = DW'(gv > MAXV ? MAXV : gv);
          exp_start = 1;
          exp_ptr = (g + 1) % N_CH;
          gorder.push_back(g);
          acc_cnt[g]++;
          if (conv_mode == 0)
            sb.push_back('{g, to_bcd(int'(exp_cd)), gv > MAXV});
        end
      end
    end
  end

  // result monitor
  bit   done_prev = 0;
  res_t e;
  always @(negedge sys_clk) begin
    if (!sys_rst && res_valid) begin
      res_cnt++;
      check("res_latency", 32'(done_prev), 1);
      if (sb.size() == 0) begin
        check("res_unexpected", 32'(res_valid), 0);
      end else begin
        e = sb.pop_front();
        check("res_ch", 32'(res_ch), 32'(e.ch));
        check("res_bcd", 32'(res_bcd), 32'(e.bcd));
        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
      end
    end
    done_prev = conv_done;
  end

  // watchdog monitor: cycles from the start pulse to timeout_err
  bit wact = 0;
  int wcnt = 0;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      wact = 0;
    end else begin
      if (wact) wcnt++;
      if (conv_start) begin
        wact = 1;
        wcnt = 0;
      end
      if (timeout_err) begin
        tmo_cnt++;
        check("timeout_active", 32'(wact), 1);
        check("timeout_cycle", 32'(wcnt), TIMEOUT + 1);
        wact = 0;
      end
      if (res_valid) wact = 0;
    end
  end

  // converter model
  logic [DW-1:0] cd;
  int            dl;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (stray_cnt != stray_done) begin
        @(posedge sys_clk); #1;
        conv_done = 1'b1;
        conv_bcd  = 24'h987654;
        @(posedge sys_clk); #1;
        conv_done = 1'b0;
        conv_bcd  = '0;
        stray_done++;
      end else if (conv_start && !sys_rst && conv_mode == 0) begin
        cd = conv_data;
        dl = conv_delay > 0 ? conv_delay : $urandom_range(1, 12);
        repeat (dl) @(posedge sys_clk);
        #1;
        check("conv_data_hold", 32'(conv_data), 32'(cd));
        conv_done = 1'b1;
        conv_bcd  = to_bcd(int'(cd));
        @(posedge sys_clk); #1;
        conv_done = 1'b0;
        conv_bcd  = '0;
      end
    end
  end

  task automatic step();
    @(posedge sys_clk); #1;
    for (int c = 0; c < N_CH; c++) begin
      if (acc_cnt[c] != taken[c]) begin
        taken[c] = acc_cnt[c];
        if (keep) req_data[c*DW +: DW] = rnd_val();
        else      req_valid[c] = 1'b0;
      end
    end
    if (rnd_mode) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!req_valid[c] && $urandom_range(0, 3) == 0) begin
          req_valid[c] = 1'b1;
          req_data[c*DW +: DW] = rnd_val();
        end
      end
    end
  endtask

  task automatic raise(int c, logic [DW-1:0] v);
    req_valid[c] = 1'b1;
    req_data[c*DW +: DW] = v;
  endtask

  task automatic wait_idle(string name, int maxc);
    int n = 0;
    step();
    while (!(req_valid == 0 && sb.size() == 0 && !busy) && n < maxc) begin
      step();
      n++;
    end
    check(name, 32'(n < maxc), 1);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_conv_start"}, 32'(conv_start), 0);
    check({tag, "_conv_data"}, 32'(conv_data), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_ch"}, 32'(res_ch), 0);
    check({tag, "_res_bcd"}, 32'(res_bcd), 0);
    check({tag, "_res_ovf"}, 32'(res_ovf), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask

  int gb;
  int t0;
  int r0;
  int n;
  initial begin
    // reset held with requests pending: nothing is accepted
    req_valid = '1;
    req_data  = {20'd5, 20'd6, 20'd7};
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_zero("rst");
    @(posedge sys_clk); #1;
    req_valid = '0;
    sys_rst   = 1'b0;
    step();

    // round robin with everyone requesting continuously
    conv_mode  = 0;
    conv_delay = 3;
    keep = 1;
    gb = gorder.size();
    for (int c = 0; c < N_CH; c++) raise(c, rnd_val());
    n = 0;
    while (gorder.size() < gb + 4 && n < 200) begin
      step();
      n++;
    end
    keep = 0;
    check("rr_grants", 32'(gorder.size() >= gb + 4), 1);
    if (gorder.size() >= gb + 4) begin
      check("rr_0", 32'(gorder[gb]), 0);
      check("rr_1", 32'(gorder[gb+1]), 1);
      check("rr_2", 32'(gorder[gb+2]), 2);
      check("rr_3", 32'(gorder[gb+3]), 0);
    end
    wait_idle("rr_idle", 400);

    // single request, slow converter
    conv_delay = 22;
    raise(1, 20'd12345);
    wait_idle("single_idle", 200);
    check("single_bcd", 32'(res_bcd), 32'h012345);

    // saturation and zero
    conv_delay = 2;
    raise(0, 20'hFFFFF);
    wait_idle("sat_idle", 100);
    check("sat_ovf", 32'(res_ovf), 1);
    raise(0, 20'd0);
    wait_idle("zero_idle", 100);
    raise(2, 20'd999999);
    wait_idle("max_idle", 100);
    raise(1, 20'd1000000);
    wait_idle("over_idle", 100);

    // watchdog: converter never answers
    conv_mode = 1;
    t0 = tmo_cnt;
    r0 = res_cnt;
    raise(0, 20'd777);
    wait_idle("wd_idle", 200);
    check("wd_fired", 32'(tmo_cnt - t0), 1);
    check("wd_no_res", 32'(res_cnt - r0), 0);
    conv_mode = 0;
    gb = gorder.size();
    raise(0, 20'd11);
    raise(1, 20'd22);
    wait_idle("wd_next_idle", 200);
    check("wd_next_ch", 32'(gorder[gb]), 1);

    // done on the cycle the watchdog reaches its limit
    conv_delay = TIMEOUT + 1;
    t0 = tmo_cnt;
    r0 = res_cnt;
    raise(2, 20'd4242);
    wait_idle("edge_idle", 300);
    check("edge_no_tmo", 32'(tmo_cnt - t0), 0);
    check("edge_res", 32'(res_cnt - r0), 1);

    // stray done while idle
    r0 = res_cnt;
    stray_cnt++;
    repeat (5) step();
    check("stray_no_res", 32'(res_cnt - r0), 0);
    check("stray_busy", 32'(busy), 0);

    // reset in the middle of WAIT, then a late done
    conv_mode = 1;
    raise(1, 20'd500);
    repeat (6) step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_zero("midrst");
    r0 = res_cnt;
    stray_cnt++;
    repeat (5) step();
    check("midrst_no_res", 32'(res_cnt - r0), 0);
    check("midrst_busy", 32'(busy), 0);
    conv_mode  = 0;
    conv_delay = 4;
    gb = gorder.size();
    raise(1, 20'd31);
    raise(2, 20'd32);
    wait_idle("midrst_idle", 200);
    check("midrst_grant", 32'(gorder[gb]), 1);

    // randomized traffic with random converter latency
    conv_delay = 0;
    r0 = res_cnt;
    rnd_mode = 1;
    n = 0;
    while (res_cnt - r0 < 40 && n < 5000) begin
      step();
      n++;
    end
    rnd_mode = 0;
    check("rnd_jobs", 32'(res_cnt - r0 >= 40), 1);
    wait_idle("rnd_idle", 500);
    check("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
